// File: rtl/branch_predictor_pkg.sv
// Shared encodings and helpers for the 2-bit counter branch predictor.
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_state_e;

  localparam int IDX_W_DEF = 4;
  localparam int ENTRIES   = 2 ** IDX_W_DEF;

  // Word index of a PC. The caller truncates it to its table index width.
  function automatic logic [31:0] pc_to_idx(input logic [31:0] pc);
    return pc >> 2;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next state of a 2-bit saturating counter, purely combinational.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] state,
  input  logic       taken,
  output logic [1:0] next_state
);

  always_comb begin
    next_state = state;
    case (state)
      SNT: next_state = taken ? WNT : SNT;
      WNT: next_state = taken ? WT  : SNT;
      WT:  next_state = taken ? ST  : WNT;
      ST:  next_state = taken ? ST  : WT;
      default: next_state = state;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// PC-indexed table of 2-bit counters: combinational ID prediction, EX-stage training
// with a one-cycle read-modify-write, plus saturating branch/mispredict statistics.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int         IDX_W      = IDX_W_DEF,
  parameter logic [1:0] INIT_STATE = 2'b10,
  parameter int         CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      ID_pc_i,
  input  logic             ID_Branch_i,
  output logic             ID_predict_o,
  input  logic             EX_Branch_i,
  input  logic [31:0]      EX_pc_i,
  input  logic             EX_zero_i,
  input  logic             EX_predict_i,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispredict_cnt_o
);

  localparam int NUM_ENT = 2 ** IDX_W;

  logic [1:0]       r_table [NUM_ENT];
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_misp_cnt;

  logic [IDX_W-1:0] w_id_idx;
  logic [IDX_W-1:0] w_ex_idx;
  logic [1:0]       w_ex_cur;
  logic [1:0]       w_ex_next;
  logic             w_misp;

  assign w_id_idx = IDX_W'(pc_to_idx(ID_pc_i));
  assign w_ex_idx = IDX_W'(pc_to_idx(EX_pc_i));
  assign w_ex_cur = r_table[w_ex_idx];
  assign w_misp   = EX_predict_i ^ EX_zero_i;

  // No write bypass: a same-cycle update to this index shows up next cycle.
  assign ID_predict_o = r_table[w_id_idx][1] & ID_Branch_i & rst_i;

  sat_counter2 u_sat (
    .state      (w_ex_cur),
    .taken      (EX_zero_i),
    .next_state (w_ex_next)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NUM_ENT; i++) begin
        r_table[i] <= INIT_STATE;
      end
    end else if (EX_Branch_i) begin
      r_table[w_ex_idx] <= w_ex_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_branch_cnt <= '0;
      r_misp_cnt   <= '0;
    end else if (EX_Branch_i) begin
      if (r_branch_cnt != '1) begin
        r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      end
      if (w_misp && (r_misp_cnt != '1)) begin
        r_misp_cnt <= r_misp_cnt + CNT_W'(1);
      end
    end
  end

  assign branch_cnt_o     = r_branch_cnt;
  assign mispredict_cnt_o = r_misp_cnt;

endmodule
